serial_msg_deframer: RTL and testbench
======================================

Name: serial_msg_deframer

Overview:
Sits directly downstream of the soft-core serial system's 32-bit bramfeeder output ("get") port. It drains raw words through the RDY/EN get handshake and parses each message header. Payload words are delivered to the LEAP channel layer on a valid/ready stream tagged with channel id, SOP and EOP. Malformed headers are discarded and counted, so the channel layer only ever sees well-framed packets.

Parameters:
FIFO_DEPTH, 4, output buffer entries (power of two, >=2)
MAX_LEN, 1024, largest legal payload length in words (<=65535)

Ports:
CLK  input  1  sole clock
RST_N  input  1  asynchronous active-low reset
get_rdy  input  1  bramfeeder RDY for output get; word available
get_data  input  32  bramfeeder output get data; valid when get_rdy=1
EN_get  output  1  dequeue strobe to bramfeeder; one word consumed per cycle asserted
chan_valid  output  1  output word valid
chan_ready  input  1  consumer accepts when chan_valid & chan_ready
chan_data  output  32  payload word
chan_id  output  8  channel id from header
chan_sop  output  1  first payload word of packet
chan_eop  output  1  last payload word of packet
hdr_err  output  1  one-cycle pulse per discarded header word
err_count  output  16  discarded header count, saturating
pkt_count  output  16  completed packets (EOP word written into FIFO), wrapping

Behaviour:
- Clock/reset: one clock CLK; reset RST_N is asynchronous, active-low. All flops clear on RST_N=0.
- Reset values: EN_get=0, chan_valid=0, chan_data/chan_id=0, chan_sop=0, chan_eop=0, hdr_err=0, err_count=0, pkt_count=0. State=HDR and FIFO empty.
- Header format: [31:28]=4'hA marker, [27:24] reserved (ignored), [23:16] channel id, [15:0] payload length in words.
- EN_get is combinational and never asserted while get_rdy=0.
  - In HDR: EN_get = get_rdy.
  - In PAYLOAD: EN_get = get_rdy & (fifo not full, or a pop happens this cycle).
- HDR state, word consumed:
  - If marker==4'hA and 1<=len<=MAX_LEN: latch id, load rem=len, set first=1, go to PAYLOAD.
  - Otherwise: pulse hdr_err the next cycle, increment err_count (saturates at 16'hFFFF), stay in HDR.
- PAYLOAD state, word consumed:
  - Push {data, id, sop=first, eop=(rem==1)} into the FIFO, clear first, decrement rem.
  - When rem==1: return to HDR and increment pkt_count in the same cycle.
  - A single-word packet has sop=eop=1.
- Header words never enter the FIFO.
- Latency: a payload word consumed in cycle N is visible on chan_* in cycle N+1 (FIFO is registered, first-word-fall-through). Minimum gap header-to-first-payload is 1 cycle. Sustained throughput is 1 word/cycle while chan_ready=1.
- FIFO:
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Push when full and no pop is impossible by construction; the bench asserts it.
  - Pop when empty is a no-op.
- chan_* outputs hold stable while chan_valid=1 and chan_ready=0.
- Back-to-back packets: the next header may be consumed the cycle after the EOP word is consumed, independent of whether the output side has drained.
- Reset mid-packet discards the FIFO contents and remaining count; parsing restarts in HDR.

Decomposition:
- Package serial_msg_pkg holds:
  - HDR_MARKER=4'hA
  - field bit positions/widths: MARKER_MSB/LSB, ID_MSB/LSB, LEN_MSB/LSB
  - state enum {HDR, PAYLOAD}
  - FIFO entry width constant (32+8+2=42)
- One sub-module, serial_msg_fifo: parameterised width and depth, synchronous FWFT FIFO with full/empty/count and async active-low reset.
- Parser FSM, counters and handshake glue stay in serial_msg_deframer.

Test Plan:
1. Header 32'hA005_0003, then payload 11,22,33, chan_ready=1 → outputs 11(id5,sop), 22, 33(eop); each word 1 cycle after EN_get; pkt_count=1.
2. Header 32'hA007_0001, then payload 99 → single beat 99 with sop=eop=1, id=7.
3. Words 32'h1234_0002 then 32'hA001_0000 → two hdr_err pulses; err_count=2; chan_valid never asserted; next valid header parses normally.
4. Header 32'hA002_0008, 8 payload words, chan_ready=0 → EN_get stops after FIFO_DEPTH (4) payload words. Raise chan_ready → all 8 delivered in order, no loss or duplicates.
5. Two packets back-to-back (len 2, id 3; len 2, id 4) with get_rdy always 1 → EN_get high every cycle, second header consumed the cycle after first EOP; output ids 3,3,4,4 with correct sop/eop.
6. Assert RST_N=0 mid-payload with 2 words buffered → chan_valid=0 immediately (async). After release, header 32'hA009_0001 + word 5 → output 5, id 9, sop=eop=1.

Source files
------------

// File: rtl/serial_msg_pkg.sv
// rtl/serial_msg_pkg.sv - shared header field layout, parser states and FIFO entry width
//
// Purpose: constants and types shared by the serial message deframer and its FIFO.
// Ports:   none (package).
package serial_msg_pkg;

  localparam logic [3:0] HDR_MARKER = 4'hA;

  localparam int MARKER_MSB = 31;
  localparam int MARKER_LSB = 28;
  localparam int ID_MSB     = 23;
  localparam int ID_LSB     = 16;
  localparam int LEN_MSB    = 15;
  localparam int LEN_LSB    = 0;

  localparam int DATA_W  = 32;
  localparam int ID_W    = ID_MSB - ID_LSB + 1;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
  // FIFO entry layout: {data, id, sop, eop}
  localparam int ENTRY_W = DATA_W + ID_W + 2;

  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

endpackage

// File: rtl/serial_msg_fifo.sv
// rtl/serial_msg_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: registered storage with the head entry always presented on dout.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, din        write request and data (ignored when full unless popping)
//   pop              read request (no-op when empty)
//   dout             head entry, valid while empty=0
//   full, empty      occupancy flags
//   count            number of stored entries
module serial_msg_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // When full, a same-cycle pop frees the slot that the push overwrites.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_msg_deframer.sv
// rtl/serial_msg_deframer.sv - parses bramfeeder words into framed channel packets
//
// Purpose: drains 32-bit words through the RDY/EN get handshake, validates headers,
//          and forwards payload words with channel id / SOP / EOP through a FIFO.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   get_rdy, get_data     upstream word available / word
//   EN_get                upstream dequeue strobe (combinational)
//   chan_valid/ready      downstream stream handshake
//   chan_data/id/sop/eop  downstream payload word and framing
//   hdr_err               one-cycle pulse per discarded header word
//   err_count             discarded header count, saturating
//   pkt_count             completed packet count, wrapping
module serial_msg_deframer
  import serial_msg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LEN    = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              get_rdy,
  input  logic [31:0]       get_data,
  output logic              EN_get,
  output logic              chan_valid,
  input  logic              chan_ready,
  output logic [31:0]       chan_data,
  output logic [7:0]        chan_id,
  output logic              chan_sop,
  output logic              chan_eop,
  output logic              hdr_err,
  output logic [15:0]       err_count,
  output logic [15:0]       pkt_count
);

  state_t                          state;
  state_t                          next_state;
  logic [ID_W-1:0]                 id_q;
  logic [LEN_W-1:0]                rem_q;
  logic                            first_q;

  logic [3:0]                      hdr_marker;
  logic [ID_W-1:0]                 hdr_id;
  logic [LEN_W-1:0]                hdr_len;
  logic                            hdr_ok;
  logic                            hdr_take;
  logic                            hdr_bad;
  logic                            push;
  logic                            pop;
  logic                            last_word;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [ENTRY_W-1:0]              fifo_din;
  logic [ENTRY_W-1:0]              fifo_dout;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                            unused_bits;

  assign hdr_marker = get_data[MARKER_MSB:MARKER_LSB];
  assign hdr_id     = get_data[ID_MSB:ID_LSB];
  assign hdr_len    = get_data[LEN_MSB:LEN_LSB];
  assign hdr_ok     = (hdr_marker == HDR_MARKER) && (hdr_len != '0) && (int'(hdr_len) <= MAX_LEN);

  // Reserved header bits and FIFO occupancy are not needed by the parser.
  assign unused_bits = ^{get_data[27:24], fifo_count};

  assign pop        = chan_valid & chan_ready;
  assign last_word  = (rem_q == LEN_W'(1));
  assign chan_valid = ~fifo_empty;
  assign fifo_din   = {get_data, id_q, first_q, last_word};
  assign {chan_data, chan_id, chan_sop, chan_eop} = fifo_dout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= HDR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    EN_get     = 1'b0;
    push       = 1'b0;
    hdr_take   = 1'b0;
    hdr_bad    = 1'b0;
    case (state)
      HDR: begin
        EN_get   = get_rdy;
        hdr_take = get_rdy & hdr_ok;
        hdr_bad  = get_rdy & ~hdr_ok;
        if (hdr_take) begin
          next_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Room exists if not full, or if the head leaves this same cycle.
        EN_get = get_rdy & (~fifo_full | pop);
        push   = EN_get;
        if (push && last_word) begin
          next_state = HDR;
        end
      end
      default: next_state = HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      id_q      <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      hdr_err   <= 1'b0;
      err_count <= '0;
      pkt_count <= '0;
    end else begin
      hdr_err <= hdr_bad;
      if (hdr_bad && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 1'b1;
      end
      if (hdr_take) begin
        id_q    <= hdr_id;
        rem_q   <= hdr_len;
        first_q <= 1'b1;
      end else if (push) begin
        rem_q   <= rem_q - 1'b1;
        first_q <= 1'b0;
      end
      if (push && last_word) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

  serial_msg_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_serial_msg_deframer.sv
// tb/tb_serial_msg_deframer.sv - directed self-checking bench for serial_msg_deframer
module tb_serial_msg_deframer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        get_rdy = 1'b0;
  logic [31:0] get_data = '0;
  logic        chan_ready = 1'b0;
  logic        EN_get;
  logic        chan_valid;
  logic [31:0] chan_data;
  logic [7:0]  chan_id;
  logic        chan_sop;
  logic        chan_eop;
  logic        hdr_err;
  logic [15:0] err_count;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [41:0] got[$];
  logic [41:0] exp_q[$];
  logic [41:0] cur;
  logic [41:0] prev_beat;
  logic        prev_stall = 1'b0;
  int          valid_cycles = 0;
  int          waits;

  always #5 CLK = ~CLK;

  serial_msg_deframer #(
    .FIFO_DEPTH (4),
    .MAX_LEN    (1024)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .get_rdy    (get_rdy),
    .get_data   (get_data),
    .EN_get     (EN_get),
    .chan_valid (chan_valid),
    .chan_ready (chan_ready),
    .chan_data  (chan_data),
    .chan_id    (chan_id),
    .chan_sop   (chan_sop),
    .chan_eop   (chan_eop),
    .hdr_err    (hdr_err),
    .err_count  (err_count),
    .pkt_count  (pkt_count)
  );

  assign cur = {chan_data, chan_id, chan_sop, chan_eop};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [41:0] bt(input logic [31:0] d, input logic [7:0] id,
                                     input logic s, input logic e);
    return {d, id, s, e};
  endfunction

  // Output monitor: capture accepted beats, check stall stability and FIFO overflow.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall <= 1'b0;
    end else begin
      check("no_push_when_full", 64'({dut.push, dut.fifo_full, dut.pop} == 3'b110), 64'd0);
      if (chan_valid) valid_cycles <= valid_cycles + 1;
      if (prev_stall && chan_valid) check("hold_stable", 64'(cur), 64'(prev_beat));
      if (chan_valid && chan_ready) got.push_back(cur);
      prev_stall <= chan_valid & ~chan_ready;
      prev_beat  <= cur;
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // Present one word; returns after the edge that consumed it. Call at posedge+1.
  task automatic put(input logic [31:0] w, output int nwait);
    bit ok;
    ok       = 1'b0;
    nwait    = 0;
    get_rdy  = 1'b1;
    get_data = w;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (EN_get) begin
        ok = 1'b1;
        break;
      end
      nwait++;
    end
    if (!ok) check("put_timeout", 64'd0, 64'd1);
    @(posedge CLK);
    #1;
    get_rdy = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    int dummy;
    put(w, dummy);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 100 && got.size() < n; k++) begin
      @(negedge CLK);
      #1;
    end
    sync();
  endtask

  task automatic cmp_beats(input string t);
    check({t, "_beats"}, 64'(got.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      check($sformatf("%s_beat%0d", t, i), 64'((i < got.size()) ? got[i] : 42'h0), 64'(exp_q[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    check("rst_en_get", 64'(EN_get), 64'd0);
    check("rst_valid", 64'(chan_valid), 64'd0);
    check("rst_data", 64'(chan_data), 64'd0);
    check("rst_id", 64'(chan_id), 64'd0);
    check("rst_sop_eop", 64'({chan_sop, chan_eop}), 64'd0);
    check("rst_hdr_err", 64'(hdr_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    #19 RST_N = 1'b1;
    sync();

    // 1: three-word packet, first-word latency
    chan_ready = 1'b1;
    got.delete();
    send(32'hA005_0003);
    send(32'd11);
    @(negedge CLK);
    check("t1_lat_valid", 64'(chan_valid), 64'd1);
    check("t1_lat_data", 64'(chan_data), 64'd11);
    check("t1_lat_id_sop", 64'({chan_id, chan_sop}), 64'({8'd5, 1'b1}));
    sync();
    send(32'd22);
    send(32'd33);
    drain(3);
    exp_q.delete();
    exp_q.push_back(bt(11, 5, 1, 0));
    exp_q.push_back(bt(22, 5, 0, 0));
    exp_q.push_back(bt(33, 5, 0, 1));
    cmp_beats("t1");
    check("t1_pkt_count", 64'(pkt_count), 64'd1);

    // 2: single-word packet
    got.delete();
    send(32'hA007_0001);
    send(32'd99);
    drain(1);
    exp_q.delete();
    exp_q.push_back(bt(99, 7, 1, 1));
    cmp_beats("t2");
    check("t2_pkt_count", 64'(pkt_count), 64'd2);

    // 3: malformed headers (bad marker, zero length, length MAX_LEN+1)
    got.delete();
    sync();
    valid_cycles = 0;
    send(32'h1234_0002);
    @(negedge CLK);
    check("t3_err_pulse1", 64'(hdr_err), 64'd1);
    check("t3_err_count1", 64'(err_count), 64'd1);
    sync();
    send(32'hA001_0000);
    @(negedge CLK);
    check("t3_err_pulse2", 64'(hdr_err), 64'd1);
    check("t3_err_count2", 64'(err_count), 64'd2);
    sync();
    @(negedge CLK);
    check("t3_err_cleared", 64'(hdr_err), 64'd0);
    sync();
    send(32'hA001_0401);
    @(negedge CLK);
    check("t3_err_count3", 64'(err_count), 64'd3);
    #1;
    check("t3_no_valid", 64'(valid_cycles), 64'd0);
    check("t3_pkt_count", 64'(pkt_count), 64'd2);
    sync();
    send(32'hA003_0001);
    send(32'd77);
    drain(1);
    exp_q.delete();
    exp_q.push_back(bt(77, 3, 1, 1));
    cmp_beats("t3");
    check("t3_pkt_after", 64'(pkt_count), 64'd3);

    // 4: backpressure fills the FIFO, EN_get stalls, then drains in order
    got.delete();
    chan_ready = 1'b0;
    send(32'hA002_0008);
    for (int i = 0; i < 4; i++) begin
      put(32'h400 + 32'(i), waits);
      check($sformatf("t4_fill_wait%0d", i), 64'(waits), 64'd0);
    end
    get_rdy  = 1'b1;
    get_data = 32'h404;
    repeat (4) begin
      @(negedge CLK);
      check("t4_stall_en", 64'(EN_get), 64'd0);
    end
    check("t4_head", 64'(cur), 64'(bt(32'h400, 2, 1, 0)));
    sync();
    chan_ready = 1'b1;
    for (int i = 4; i < 8; i++) send(32'h400 + 32'(i));
    drain(8);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(bt(32'h400 + 32'(i), 2, i == 0, i == 7));
    cmp_beats("t4");
    check("t4_pkt_count", 64'(pkt_count), 64'd4);

    // 5: back-to-back packets with get_rdy held high
    got.delete();
    begin
      logic [31:0] words [6];
      words = '{32'hA003_0002, 32'h501, 32'h502, 32'hA004_0002, 32'h503, 32'h504};
      for (int i = 0; i < 6; i++) begin
        put(words[i], waits);
        check($sformatf("t5_en_word%0d", i), 64'(waits), 64'd0);
      end
    end
    drain(4);
    exp_q.delete();
    exp_q.push_back(bt(32'h501, 3, 1, 0));
    exp_q.push_back(bt(32'h502, 3, 0, 1));
    exp_q.push_back(bt(32'h503, 4, 1, 0));
    exp_q.push_back(bt(32'h504, 4, 0, 1));
    cmp_beats("t5");
    check("t5_pkt_count", 64'(pkt_count), 64'd6);

    // 6: asynchronous reset mid-payload with two words buffered
    chan_ready = 1'b0;
    send(32'hA00B_0004);
    send(32'h600);
    send(32'h601);
    check("t6_pre_valid", 64'(chan_valid), 64'd1);
    #3 RST_N = 1'b0;
    #1;
    check("t6_rst_valid", 64'(chan_valid), 64'd0);
    check("t6_rst_pkt", 64'(pkt_count), 64'd0);
    check("t6_rst_err", 64'(err_count), 64'd0);
    #7 RST_N = 1'b1;
    sync();
    got.delete();
    chan_ready = 1'b1;
    send(32'hA009_0001);
    send(32'd5);
    drain(1);
    exp_q.delete();
    exp_q.push_back(bt(5, 9, 1, 1));
    cmp_beats("t6");
    check("t6_pkt_count", 64'(pkt_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
